// File: rtl/hv_stream_fifo_pkg.sv
// Shared types and helpers for the hv_stream_fifo slice.
// Holds the pointer-width helper, the handshake classification and the mode encodings.
package hv_stream_fifo_pkg;

  // Writer behaviour when the FIFO is full.
  localparam bit MODE_BLOCK     = 1'b0;
  localparam bit MODE_OVERWRITE = 1'b1;

  // Per-cycle handshake outcome, encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    XFER_NONE = 2'b00,
    XFER_RD   = 2'b01,
    XFER_WR   = 2'b10,
    XFER_BOTH = 2'b11
  } xfer_e;

  // Smallest width that can index 'value' entries; at least 1 bit.
  function automatic int unsigned ceil_log2(input int unsigned value);
    int unsigned res;
    res = 0;
    while ((32'd1 << res) < value) res++;
    if (res == 0) res = 1;
    return res;
  endfunction

endpackage

// File: rtl/hv_stream_fifo_ring_ptr.sv
// Circular pointer for the FIFO: enable, synchronous clear, modulo-DEPTH wrap.
// Wraps explicitly at DEPTH-1, so DEPTH need not be a power of two.
module hv_stream_fifo_ring_ptr
  import hv_stream_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = ceil_log2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] ptr
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clr) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == WIDTH'(DEPTH - 1)) ? '0 : ptr + WIDTH'(1);
    end
  end

endmodule

// File: rtl/hv_stream_fifo.sv
// Valid/ready synchronous FIFO with first-word-fall-through output, status flags
// and an optional overwrite-oldest mode for sliding-window buffering.
module hv_stream_fifo
  import hv_stream_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 32,
  parameter int unsigned AF_THRESH  = DEPTH - 4,
  parameter bit          OVERWRITE  = MODE_BLOCK
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [0:DATA_WIDTH-1]               din,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic [0:DATA_WIDTH-1]               dout,
  output logic [ceil_log2(DEPTH):0]           count,
  output logic                                full,
  output logic                                empty,
  output logic                                almost_full,
  output logic                                overflow,
  input  logic                                clr_overflow
);

  localparam int unsigned ADDR_WIDTH = ceil_log2(DEPTH);
  localparam int unsigned CNT_WIDTH  = ADDR_WIDTH + 1;

  logic [0:DATA_WIDTH-1] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CNT_WIDTH-1:0]  count_d;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  drop_oldest;
  logic                  ovf_set;
  xfer_e                 xfer;

  // Handshakes depend only on registered state and rst, never on the far side's strobe.
  assign in_ready    = rst && ((OVERWRITE == MODE_OVERWRITE) || !full);
  assign out_valid   = !empty;
  assign wr_acc      = in_valid && in_ready;
  assign rd_acc      = out_valid && out_ready;
  assign drop_oldest = wr_acc && !rd_acc && full;
  assign ovf_set     = drop_oldest && !flush;
  assign dout        = mem[rd_ptr];

  hv_stream_fifo_ring_ptr #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (wr_acc),
    .ptr (wr_ptr)
  );

  // Read pointer also steps when an overwrite discards the oldest entry.
  hv_stream_fifo_ring_ptr #(
    .DEPTH (DEPTH),
    .WIDTH (ADDR_WIDTH)
  ) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .en  (rd_acc || drop_oldest),
    .ptr (rd_ptr)
  );

  // Storage has no reset; flush leaves contents untouched.
  always_ff @(posedge clk) begin
    if (wr_acc && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  always_comb begin
    count_d = count;
    xfer    = xfer_e'({wr_acc, rd_acc});
    case (xfer)
      XFER_WR: if (!full) count_d = count + CNT_WIDTH'(1);
      XFER_RD: count_d = count - CNT_WIDTH'(1);
      default: count_d = count;
    endcase
    if (flush) count_d = '0;
  end

  // Flags are registered from the next occupancy so they line up with count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      count       <= count_d;
      empty       <= (count_d == '0);
      full        <= (count_d == CNT_WIDTH'(DEPTH));
      almost_full <= (count_d >= CNT_WIDTH'(AF_THRESH));
      if (ovf_set) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
